// File: rtl/tach_pkg.sv
// Shared helpers for the multi-channel tachometer: gate length, counter widths,
// saturating increment and the optional glitch-filter length (macro TACH_FILTER_EN).
package tach_pkg;

    // Number of clocks in one gate window.
    function automatic int gate_clocks(input int clock_freq, input int gate_hz);
        return clock_freq / gate_hz;
    endfunction

    // Width of a counter that runs 0..n-1 (at least one bit).
    function automatic int gate_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Effective filter length: 0 means the filter is not built.
    function automatic int filter_len(input int cycles);
`ifdef TACH_FILTER_EN
        return cycles;
`else
        return (cycles < 0) ? cycles : 0;
`endif
    endfunction

    // value + 1, clamped at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] ones;
        ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= ones) ? ones : value + 64'd1;
    endfunction

endpackage

// File: rtl/tach_channel.sv
// One tachometer channel: synchroniser, optional glitch filter (TACH_FILTER_EN),
// rising-edge detect, saturating pulse counter and saturation flag.
// Ports: clock, system_reset (async, high), clear (drop window), capture (terminal
// cycle), encoder_in (raw); capture_count / capture_sat are the window result
// including an edge seen in the current cycle.
module tach_channel
    import tach_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clock,
    input  logic             system_reset,
    input  logic             clear,
    input  logic             capture,
    input  logic             encoder_in,
    output logic [CNT_W-1:0] capture_count,
    output logic             capture_sat
);

    localparam int FILT_LEN = filter_len(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   synced;
    logic                   level;
    logic                   edge_det;
    logic [CNT_W-1:0]       cnt_inc;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], encoder_in};
    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (FILT_LEN > 0) begin : g_filter
            localparam int FW = $clog2(FILT_LEN + 1);

            logic          filt_q, filt_d;
            logic [FW-1:0] fcnt_q, fcnt_d;

            // Level follows the synced input only after FILT_LEN stable cycles;
            // any return to the current level restarts the count.
            always_comb begin
                filt_d = filt_q;
                fcnt_d = '0;
                if (synced != filt_q) begin
                    if (fcnt_q == FW'(FILT_LEN - 1)) begin
                        filt_d = synced;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock or posedge system_reset) begin
                if (system_reset) begin
                    filt_q <= 1'b0;
                    fcnt_q <= '0;
                end else begin
                    filt_q <= filt_d;
                    fcnt_q <= fcnt_d;
                end
            end

            assign level = filt_q;
        end else begin : g_no_filter
            assign level = synced;
        end
    endgenerate

    assign edge_det = level & ~prev_q;
    assign prev_d   = level;
    assign cnt_inc  = CNT_W'(sat_inc(64'(cnt_q), CNT_W));

    // Window result as if this cycle's edge were already counted.
    assign capture_count = edge_det ? cnt_inc : cnt_q;
    assign capture_sat   = sat_q | (edge_det & (&cnt_q));

    always_comb begin
        cnt_d = capture_count;
        sat_d = capture_sat;
        if (clear || capture) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: rtl/multi_tachometer.sv
// Multi-channel tachometer: counts encoder rising edges per channel over a shared
// gate window and publishes all counts together with a one-cycle sample_valid.
// Ports: clock, system_reset (async, high), enable, encoder_in[NUM_CH];
// data_out (channel i at [i*CNT_W +: CNT_W]), sample_valid, overflow[NUM_CH].
// Optional glitch filter: define TACH_FILTER_EN.
module multi_tachometer
    import tach_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 32,
    parameter int CLOCK_FREQ    = 100000000,
    parameter int GATE_HZ       = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    system_reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       encoder_in,
    output logic [NUM_CH*CNT_W-1:0] data_out,
    output logic                    sample_valid,
    output logic [NUM_CH-1:0]       overflow
);

    localparam int GATE_CLOCKS = gate_clocks(CLOCK_FREQ, GATE_HZ);
    localparam int GATE_W      = gate_w(GATE_CLOCKS);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CLOCKS - 1);

    logic [GATE_W-1:0]       gate_q, gate_d;
    logic [NUM_CH*CNT_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0]       ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    terminal;
    logic                    clear;
    logic [NUM_CH*CNT_W-1:0] cap_count;
    logic [NUM_CH-1:0]       cap_sat;

    assign terminal = enable & (gate_q == GATE_LAST);
    assign clear    = ~enable;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            tach_channel #(
                .CNT_W        (CNT_W),
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_ch (
                .clock        (clock),
                .system_reset (system_reset),
                .clear        (clear),
                .capture      (terminal),
                .encoder_in   (encoder_in[i]),
                .capture_count(cap_count[i*CNT_W +: CNT_W]),
                .capture_sat  (cap_sat[i])
            );
        end
    endgenerate

    always_comb begin
        gate_d  = gate_q + 1'b1;
        data_d  = data_q;
        ovf_d   = ovf_q;
        valid_d = terminal;
        if (!enable || terminal) begin
            gate_d = '0;
        end
        if (terminal) begin
            data_d = cap_count;
            ovf_d  = cap_sat;
        end
    end

    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            gate_q  <= '0;
            data_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            gate_q  <= gate_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign data_out     = data_q;
    assign overflow     = ovf_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_multi_tachometer.sv
// Directed testbench for multi_tachometer: a 10-cycle-gate instance for window,
// reset and enable behaviour, and a 100-cycle CNT_W=4 instance for saturation/filter.
module tb_multi_tachometer;

    logic         clock = 1'b0;
    logic         system_reset;
    logic         enable;
    logic [3:0]   enc;
    logic [127:0] data_out;
    logic         sample_valid;
    logic [3:0]   overflow;

    logic         enable_s;
    logic [3:0]   enc_s;
    logic [15:0]  data_s;
    logic         valid_s;
    logic [3:0]   ovf_s;

    int n_cmp = 0;
    int n_bad = 0;
    int n;
    int sv_seen;

`ifdef TACH_FILTER_EN
    localparam int FILT_EXP = 2;
`else
    localparam int FILT_EXP = 4;
`endif

    always #5 clock = ~clock;

    multi_tachometer #(
        .NUM_CH(4), .CNT_W(32), .CLOCK_FREQ(1000), .GATE_HZ(100),
        .SYNC_STAGES(2), .FILTER_CYCLES(4)
    ) dut (
        .clock(clock), .system_reset(system_reset), .enable(enable),
        .encoder_in(enc), .data_out(data_out),
        .sample_valid(sample_valid), .overflow(overflow)
    );

    multi_tachometer #(
        .NUM_CH(4), .CNT_W(4), .CLOCK_FREQ(1000), .GATE_HZ(10),
        .SYNC_STAGES(2), .FILTER_CYCLES(4)
    ) dut_s (
        .clock(clock), .system_reset(system_reset), .enable(enable_s),
        .encoder_in(enc_s), .data_out(data_s),
        .sample_valid(valid_s), .overflow(ovf_s)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        system_reset = 1'b1;
        enable = 1'b0;
        enable_s = 1'b0;
        enc = '0;
        enc_s = '0;
        tick();
        tick();
        check("reset_data", data_out, 128'd0);
        check("reset_valid", 128'(sample_valid), 128'd0);
        check("reset_ovf", 128'(overflow), 128'd0);
        system_reset = 1'b0;
        tick();

        // first window after enable
        enable = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (sample_valid) break;
        end
        check("first_valid_latency", 128'(n), 128'd10);

        // ch0 three pulses, ch2 one pulse, in one window
        repeat (8) tick();
        enc = 4'b0101;
        tick(); tick();
        check("quiet_window", data_out, 128'd0);
        enc = 4'b0000;
        tick(); tick();
        enc = 4'b0001;
        tick(); tick();
        enc = 4'b0000;
        tick(); tick();
        enc = 4'b0001;
        tick(); tick();
        enc = 4'b0000;
        tick(); tick();
        check("multi_valid", 128'(sample_valid), 128'd1);
        check("multi_data", data_out, {32'd0, 32'd1, 32'd0, 32'd3});
        check("multi_ovf", 128'(overflow), 128'd0);
        tick();
        check("valid_one_cycle", 128'(sample_valid), 128'd0);

        // edge lands in the terminal cycle
        repeat (6) tick();
        enc = 4'b0001;
        tick(); tick();
        enc = 4'b0000;
        tick();
        check("terminal_valid", 128'(sample_valid), 128'd1);
        check("terminal_edge", data_out, 128'd1);

        // edge one cycle after terminal spills into the next window
        repeat (8) tick();
        enc = 4'b0001;
        tick(); tick();
        check("after_terminal_zero", data_out, 128'd0);
        enc = 4'b0000;
        repeat (10) tick();
        check("spill_next_window", data_out, 128'd1);

        // asynchronous reset in mid window with counts pending
        enc = 4'b0001;
        repeat (3) tick();
        enc = 4'b0000;
        tick();
        #2;
        system_reset = 1'b1;
        enable = 1'b0;
        #1;
        check("async_rst_data", data_out, 128'd0);
        check("async_rst_valid", 128'(sample_valid), 128'd0);
        check("async_rst_ovf", 128'(overflow), 128'd0);
        tick(); tick();
        system_reset = 1'b0;
        tick(); tick();
        enable = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 2) enc[3] = 1'b1;
            if (n == 4) enc[3] = 1'b0;
            if (sample_valid) break;
        end
        check("post_rst_latency", 128'(n), 128'd10);
        check("post_rst_data", data_out, 128'd1 << 96);

        // enable dropped while ch1 keeps pulsing
        repeat (3) tick();
        enable = 1'b0;
        sv_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (i % 4 == 0 && i < 24) enc[1] = 1'b1;
            if (i % 4 == 2) enc[1] = 1'b0;
            tick();
            if (sample_valid) sv_seen++;
        end
        check("disabled_no_valid", 128'(sv_seen), 128'd0);
        check("disabled_hold", data_out, 128'd1 << 96);
        enable = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 1) enc[1] = 1'b1;
            if (n == 3) enc[1] = 1'b0;
            if (n == 5) enc[1] = 1'b1;
            if (n == 7) enc[1] = 1'b0;
            if (sample_valid) break;
        end
        check("reenable_latency", 128'(n), 128'd10);
        check("reenable_data", data_out, 128'd2 << 32);

        // saturation: 20 pulses into a 4-bit counter
        enable_s = 1'b1;
        n = 0;
        while (n < 300) begin
            if (n < 80 && n % 4 == 0) enc_s[0] = 1'b1;
            if (n % 4 == 2) enc_s[0] = 1'b0;
            tick();
            n++;
            if (valid_s) break;
        end
        check("sat_latency", 128'(n), 128'd100);
        check("sat_data", 128'(data_s), 128'd15);
        check("sat_ovf", 128'(ovf_s), 128'd1);
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (valid_s) break;
        end
        check("quiet_latency", 128'(n), 128'd100);
        check("quiet_data", 128'(data_s), 128'd0);
        check("quiet_ovf", 128'(ovf_s), 128'd0);

        // 2-cycle glitches and 6-cycle pulses on ch1
        n = 0;
        while (n < 300) begin
            enc_s[1] = (n < 2) || (n >= 6 && n < 12) ||
                       (n >= 18 && n < 20) || (n >= 24 && n < 30);
            tick();
            n++;
            if (valid_s) break;
        end
        check("glitch_latency", 128'(n), 128'd100);
        check("glitch_data", 128'(data_s), 128'(FILT_EXP) << 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
